// File: rtl/lights_nios2_qsys_0_ocimem.sv
// Nios II on-chip debug memory: JTAG monitor access (MonAReg/MonDReg) to a
// single-port debug RAM, shared with an Avalon-MM slave and a status register.
module lights_nios2_qsys_0_ocimem #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W:0]   avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {IDLE, J_RD, C_RD} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_SETA, OP_WRITE, OP_INCA} op_t;

  state_t            state, state_nxt;
  op_t               in_op, exec_op, pend_op, pend_op_nxt;
  logic              pend_v, pend_v_nxt;
  logic [37:0]       pend_jdo, pend_jdo_nxt, exec_jdo;
  logic              j_cap, j_cap_nxt;
  logic [ADDR_W-1:0] MonAReg, areg_nxt;
  logic [31:0]       dreg_nxt;
  logic              rdy_nxt, err_nxt, ovf, ovf_nxt;
  logic              multi, drop, jtag_clr, is_ctrl, ctrl_wr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_q;
  logic [31:0]       mem [0:(1 << ADDR_W) - 1];
  logic              unused_jdo;

  assign is_ctrl    = avs_address[ADDR_W];
  assign ctrl_wr    = (state == IDLE) & avs_write & is_ctrl;
  assign multi      = (take_action_ocimem_a & take_action_ocimem_b) |
                      (take_action_ocimem_a & take_no_action_ocimem_a) |
                      (take_action_ocimem_b & take_no_action_ocimem_a);
  assign unused_jdo = ^{exec_jdo[37:36], exec_jdo[1:0]};

  always_comb begin
    in_op = OP_NONE;
    if (take_action_ocimem_a)         in_op = OP_SETA;
    else if (take_action_ocimem_b)    in_op = OP_WRITE;
    else if (take_no_action_ocimem_a) in_op = OP_INCA;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      j_cap         <= 1'b0;
      pend_v        <= 1'b0;
      pend_op       <= OP_NONE;
      pend_jdo      <= '0;
      MonAReg       <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      ovf           <= 1'b0;
    end else begin
      state         <= state_nxt;
      j_cap         <= j_cap_nxt;
      pend_v        <= pend_v_nxt;
      pend_op       <= pend_op_nxt;
      pend_jdo      <= pend_jdo_nxt;
      MonAReg       <= areg_nxt;
      MonDReg       <= dreg_nxt;
      monitor_ready <= rdy_nxt;
      monitor_error <= err_nxt;
      ovf           <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    j_cap_nxt    = 1'b0;
    pend_v_nxt   = pend_v;
    pend_op_nxt  = pend_op;
    pend_jdo_nxt = pend_jdo;
    areg_nxt     = MonAReg;
    dreg_nxt     = MonDReg;
    exec_op      = OP_NONE;
    exec_jdo     = jdo;
    drop         = 1'b0;
    jtag_clr     = 1'b0;
    ram_we       = 1'b0;
    ram_be       = '0;
    ram_addr     = MonAReg;
    ram_wdata    = avs_writedata;

    if (state == IDLE) begin
      // The slot drains this cycle, so a strobe arriving now refills it
      // rather than counting as an overflow.
      if (pend_v) begin
        exec_op      = pend_op;
        exec_jdo     = pend_jdo;
        pend_v_nxt   = (in_op != OP_NONE);
        pend_op_nxt  = in_op;
        pend_jdo_nxt = jdo;
      end else begin
        exec_op = in_op;
      end
    end else if (in_op != OP_NONE) begin
      if (pend_v) begin
        drop = 1'b1;
      end else begin
        pend_v_nxt   = 1'b1;
        pend_op_nxt  = in_op;
        pend_jdo_nxt = jdo;
      end
    end

    case (state)
      IDLE: begin
        case (exec_op)
          OP_SETA: begin
            areg_nxt  = exec_jdo[ADDR_W+1:2];
            jtag_clr  = exec_jdo[35];
            state_nxt = J_RD;
          end
          OP_WRITE: begin
            ram_we    = 1'b1;
            ram_be    = '1;
            ram_wdata = exec_jdo[34:3];
            dreg_nxt  = exec_jdo[34:3];
            areg_nxt  = MonAReg + 1'b1;
          end
          OP_INCA: begin
            areg_nxt  = MonAReg + 1'b1;
            state_nxt = J_RD;
          end
          default: begin
            if (!is_ctrl && avs_write) begin
              ram_we   = 1'b1;
              ram_be   = avs_byteenable;
              ram_addr = avs_address[ADDR_W-1:0];
            end else if (!is_ctrl && avs_read) begin
              ram_addr  = avs_address[ADDR_W-1:0];
              state_nxt = C_RD;
            end
          end
        endcase
      end
      J_RD: begin
        if (!j_cap) begin
          j_cap_nxt = 1'b1;
        end else begin
          dreg_nxt  = ram_q;
          state_nxt = IDLE;
        end
      end
      C_RD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    rdy_nxt = (monitor_ready | (ctrl_wr & avs_writedata[0])) & ~jtag_clr;
    err_nxt = (monitor_error | (ctrl_wr & avs_writedata[1])) & ~jtag_clr;
    ovf_nxt = (ovf & ~(ctrl_wr & avs_writedata[2])) | multi | drop;
  end

  // Control-register accesses never touch the RAM, so in IDLE they complete
  // alongside a JTAG strobe; this is what lets a same-cycle clear win.
  always_comb begin
    avs_waitrequest = 1'b0;
    avs_readdata    = '0;
    if (state == C_RD) begin
      avs_readdata = ram_q;
    end else if (avs_read | avs_write) begin
      if (is_ctrl)
        avs_waitrequest = (state != IDLE);
      else
        avs_waitrequest = (state != IDLE) | pend_v | (in_op != OP_NONE) | avs_read;
      if (is_ctrl && avs_read && state == IDLE)
        avs_readdata = {29'b0, ovf, monitor_error, monitor_ready};
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++)
      if (ram_we && ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    ram_q <= mem[ram_addr];
  end

endmodule
